data_memory: RTL and testbench
==============================

# data_memory

Byte-addressable, little-endian data memory that sits behind the data cache in the RISC-V core's load/store path. It takes a 4-bit access mode, a 32-bit byte address and 32-bit write data. Loads return a sign- or zero-extended result combinationally. Stores commit byte, halfword or word data on the rising clock edge.

## Interface
Parameters:
- ADDR_WIDTH, 32: width of the address input A.
- DATA_WIDTH, 32: width of WD and RD.
- MEM_BYTES, 4096: storage size in bytes; must be a power of two.

Ports:
- clk  input  1  clock; all writes occur on its rising edge.
- reset  input  1  reset, asynchronous, active-high.
- AddrMode  input  4  access mode (encoding below).
- A  input  ADDR_WIDTH  byte address.
- WD  input  DATA_WIDTH  store data; only the low byte or low halfword is used for SB/SH.
- RD  output  DATA_WIDTH  load result, combinational.

## Operation
- Storage is an array of MEM_BYTES bytes.
- Effective address = A mod MEM_BYTES (upper bits ignored).
- Byte i of a multi-byte access is at (effective address + i) mod MEM_BYTES. Byte 0 is the least significant (little-endian).
- Misaligned halfword and word accesses are legal and use consecutive bytes with wrap-around; there is no alignment fault.
- AddrMode encoding:
  - 0000 LB: RD = sign-extended byte.
  - 0001 LH: RD = sign-extended halfword.
  - 0010 LW: RD = word.
  - 0011 LBU: RD = zero-extended byte.
  - 0100 LHU: RD = zero-extended halfword.
  - 0101 SB: write WD[7:0] to byte 0.
  - 0110 SH: write WD[15:0] to bytes 0–1.
  - 0111 SW: write WD[31:0] to bytes 0–3.
  - 1000–1111: no operation; RD = 0; no write.
- During store modes, RD presents the current (pre-write) word at A, the same as LW. The cache uses this to fill a line on a store miss.
- Only the addressed bytes change on a store; all other bytes are untouched.
- Reset: while reset is high, every byte is asynchronously forced to 0x00 and writes are ignored. RD then reflects zeroed contents, i.e. 0 for every mode.

## Timing
- Read path is fully combinational: RD follows A, AddrMode and the array contents within the same cycle. Zero-cycle latency.
- Write path: store data is captured at the rising edge of clk when AddrMode is a store and reset is low. The new contents appear on RD immediately after that edge.
- Read-during-write, same cycle: RD shows old data before the edge and new data after it. There is no write-through bypass.
- Reset asserted mid-operation aborts any pending store. Deassertion takes effect synchronously to the next rising edge; the first edge with reset low may write.
- No handshake. Every access completes in one cycle.
- RD value while reset is asserted: 0x00000000.

## Test plan
- Reset: assert reset, then LW at 0x000, 0x7FC and 0xFFC -> RD = 0x00000000 for each.
- Word and sub-word loads: SW 0x8081_F0F7 at 0x100.
  - LW 0x100 -> 0x8081F0F7.
  - LB 0x100 -> 0xFFFFFFF7.
  - LBU 0x100 -> 0x000000F7.
  - LH 0x102 -> 0xFFFF8081.
  - LHU 0x102 -> 0x00008081.
  - LB 0x101 -> 0xFFFFFFF0.
- Partial stores over an existing word: SW 0x11223344 at 0x200, then SB 0xAA at 0x201, then SH 0xBEEF at 0x202 -> LW 0x200 = 0xBEEFAA44. Neighbouring words 0x1FC and 0x204 stay unchanged.
- Misaligned access and wrap-around:
  - SW 0xDEADBEEF at 0x0FFE (MEM_BYTES = 4096). Bytes land at 0xFFE, 0xFFF, 0x000, 0x001.
  - LW 0x0FFE -> 0xDEADBEEF.
  - LHU 0x000 -> 0x0000DEAD.
  - Address 0x1000_0FFE aliases to the same location.
- Store-mode read and same-cycle ordering: word at 0x300 holds 0x12345678; apply SW 0xCAFEF00D at 0x300.
  - Before the edge: RD = 0x12345678.
  - After the edge: RD = 0xCAFEF00D.
- Invalid modes and mid-cycle reset:
  - AddrMode 1000 with WD = 0xFFFFFFFF at 0x100 -> RD = 0 and memory is unchanged.
  - Assert reset between edges during an SW -> RD immediately reads 0 and no write is committed.

Source files
------------

// File: rtl/data_memory_if.sv
// data_memory_if: load/store bus between the data cache and the data memory
interface data_memory_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [3:0]            AddrMode;
    logic [ADDR_WIDTH-1:0] A;
    logic [DATA_WIDTH-1:0] WD;
    logic [DATA_WIDTH-1:0] RD;
    modport master (output AddrMode, output A, output WD, input RD);
    modport slave  (input AddrMode, input A, input WD, output RD);
endinterface

// File: rtl/data_memory.sv
// data_memory: byte-addressable little-endian memory with combinational loads and clocked stores
module data_memory #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_BYTES  = 4096
) (
    input logic         clk,
    input logic         reset,
    data_memory_if.slave bus
);
    localparam int AW = $clog2(MEM_BYTES);
    logic [7:0]    mem_q [MEM_BYTES];
    logic [7:0]    mem_d [MEM_BYTES];
    logic [AW-1:0] a0, a1, a2, a3;
    logic [7:0]    b0;
    logic [15:0]   h;
    logic [31:0]   w, rd;
    logic [3:0]    m;
    logic          st_b, st_h, st_w;
    // Address bits above the array size alias onto the same bytes.
    logic          unused_hi;
    assign unused_hi = ^bus.A[ADDR_WIDTH-1:AW];
    assign m  = bus.AddrMode;
    assign a0 = bus.A[AW-1:0];
    assign a1 = a0 + AW'(1);
    assign a2 = a0 + AW'(2);
    assign a3 = a0 + AW'(3);
    assign b0 = mem_q[a0];
    assign h  = {mem_q[a1], b0};
    assign w  = {mem_q[a3], mem_q[a2], h};
    assign st_b = (m == 4'd5) || (m == 4'd6) || (m == 4'd7);
    assign st_h = (m == 4'd6) || (m == 4'd7);
    assign st_w = (m == 4'd7);
    // Load result; store modes show the pre-write word for cache line fill.
    always_comb begin
        rd = (m == 4'd0) ? {{24{b0[7]}}, b0} :
             (m == 4'd1) ? {{16{h[15]}}, h} :
             (m == 4'd3) ? {24'd0, b0} :
             (m == 4'd4) ? {16'd0, h} :
             ((m == 4'd2) || st_b) ? w : 32'd0;
    end
    assign bus.RD = DATA_WIDTH'(rd);
    // Next array contents: only the bytes covered by the store change.
    always_comb begin
        mem_d = mem_q;
        if (st_b) mem_d[a0] = bus.WD[7:0];
        if (st_h) mem_d[a1] = bus.WD[15:8];
        if (st_w) mem_d[a2] = bus.WD[23:16];
        if (st_w) mem_d[a3] = bus.WD[31:24];
    end
    // Storage; reset clears every byte immediately and blocks writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) mem_q <= '{default: 8'h00};
        else       mem_q <= mem_d;
    end
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: randomized and directed check of data_memory against a byte-array model
module tb_data_memory;
    logic clk = 0;
    logic reset = 1;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [7:0] ref_mem [0:4095];
    data_memory_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
    data_memory #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_BYTES(4096)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_byte(input logic [31:0] a, input int i);
        return ref_mem[(a % 4096 + i) % 4096];
    endfunction

    function automatic logic [31:0] ref_rd(input logic [3:0] m, input logic [31:0] a);
        logic [31:0] bv, hv, wv;
        bv = {24'd0, ref_byte(a, 0)};
        hv = {16'd0, ref_byte(a, 1), ref_byte(a, 0)};
        wv = {ref_byte(a, 3), ref_byte(a, 2), hv[15:0]};
        case (m)
            4'd0: return bv[7] ? bv | 32'hFFFF_FF00 : bv;
            4'd1: return hv[15] ? hv | 32'hFFFF_0000 : hv;
            4'd2, 4'd5, 4'd6, 4'd7: return wv;
            4'd3: return bv;
            4'd4: return hv;
            default: return 32'd0;
        endcase
    endfunction

    task automatic ref_wr(input logic [3:0] m, input logic [31:0] a, input logic [31:0] d);
        int n;
        n = (m == 4'd5) ? 1 : (m == 4'd6) ? 2 : (m == 4'd7) ? 4 : 0;
        for (int i = 0; i < n; i++) ref_mem[(a % 4096 + i) % 4096] = 8'((d >> (8 * i)) & 32'hFF);
    endtask

    task automatic clear_ref();
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
    endtask

    task automatic op(input logic [3:0] m, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.AddrMode = m;
        bus.A = a;
        bus.WD = d;
        #1;
        check("pre_edge", bus.RD, ref_rd(m, a));
        @(posedge clk);
        #1;
        if (!reset) ref_wr(m, a, d);
        check("post_edge", bus.RD, ref_rd(m, a));
    endtask

    initial begin
        logic [3:0]  m;
        logic [31:0] a, d;
        bus.AddrMode = 4'd8;
        bus.A = 0;
        bus.WD = 0;
        clear_ref();
        op(4'd2, 32'h000, 0);      check("rst_lw000", bus.RD, 32'h0);
        op(4'd2, 32'h7FC, 0);      check("rst_lw7fc", bus.RD, 32'h0);
        op(4'd7, 32'hFFC, 32'hFFFF_FFFF);
        check("rst_sw_ignored", bus.RD, 32'h0);
        @(negedge clk);
        reset = 0;
        bus.AddrMode = 4'd8;
        op(4'd7, 32'h100, 32'h8081_F0F7);
        op(4'd2, 32'h100, 0);      check("lw100", bus.RD, 32'h8081F0F7);
        op(4'd0, 32'h100, 0);      check("lb100", bus.RD, 32'hFFFFFFF7);
        op(4'd3, 32'h100, 0);      check("lbu100", bus.RD, 32'h000000F7);
        op(4'd1, 32'h102, 0);      check("lh102", bus.RD, 32'hFFFF8081);
        op(4'd4, 32'h102, 0);      check("lhu102", bus.RD, 32'h00008081);
        op(4'd0, 32'h101, 0);      check("lb101", bus.RD, 32'hFFFFFFF0);
        op(4'd7, 32'h200, 32'h1122_3344);
        op(4'd5, 32'h201, 32'hFFFF_FFAA);
        op(4'd6, 32'h202, 32'hFFFF_BEEF);
        op(4'd2, 32'h200, 0);      check("lw200", bus.RD, 32'hBEEFAA44);
        op(4'd2, 32'h1FC, 0);      check("lw1fc", bus.RD, 32'h0);
        op(4'd2, 32'h204, 0);      check("lw204", bus.RD, 32'h0);
        op(4'd7, 32'h0FFE, 32'hDEAD_BEEF);
        op(4'd2, 32'h0FFE, 0);     check("lw_wrap", bus.RD, 32'hDEADBEEF);
        op(4'd4, 32'h000, 0);      check("lhu000", bus.RD, 32'h0000DEAD);
        op(4'd2, 32'h1000_0FFE, 0); check("lw_alias", bus.RD, 32'hDEADBEEF);
        op(4'd7, 32'h300, 32'h1234_5678);
        @(negedge clk);
        bus.AddrMode = 4'd7;
        bus.A = 32'h300;
        bus.WD = 32'hCAFE_F00D;
        #1;
        check("sw_before_edge", bus.RD, 32'h12345678);
        @(posedge clk);
        #1;
        ref_wr(4'd7, 32'h300, 32'hCAFE_F00D);
        check("sw_after_edge", bus.RD, 32'hCAFEF00D);
        op(4'd8, 32'h100, 32'hFFFF_FFFF);
        check("nop_rd", bus.RD, 32'h0);
        op(4'd2, 32'h100, 0);      check("nop_nowrite", bus.RD, 32'h8081F0F7);
        op(4'd15, 32'h300, 32'hFFFF_FFFF);
        check("nop15_rd", bus.RD, 32'h0);
        for (int i = 0; i < 400; i++) begin
            m = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 2))
                0: a = 32'($urandom_range(0, 31));
                1: a = 32'h0FF0 + 32'($urandom_range(0, 31));
                default: a = ($urandom & 32'hFFFF_F000) | 32'h100 | 32'($urandom_range(0, 31));
            endcase
            d = $urandom;
            op(m, a, d);
        end
        @(negedge clk);
        bus.AddrMode = 4'd7;
        bus.A = 32'h100;
        bus.WD = 32'h5555_AAAA;
        #1;
        check("pre_reset", bus.RD, ref_rd(4'd7, 32'h100));
        reset = 1;
        #1;
        clear_ref();
        check("midreset_rd", bus.RD, 32'h0);
        @(posedge clk);
        #1;
        check("midreset_edge", bus.RD, 32'h0);
        @(negedge clk);
        reset = 0;
        bus.AddrMode = 4'd2;
        #1;
        check("midreset_nowrite", bus.RD, 32'h0);
        op(4'd7, 32'h100, 32'h0BAD_F00D);
        op(4'd2, 32'h100, 0);      check("post_reset_write", bus.RD, 32'h0BADF00D);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
